i2s_rx_sampler: RTL

Front-end capture stage of the audio chain. Deserialises a standard I2S stream from the external ADC, clocked as BCLK/LRCK/SDATA, into 16-bit two's-complement samples for one selected channel. Its output pair `audio_data`/`data_valid` drives the dB level calculator directly. All I2S pins are asynchronous to `clk` and are oversampled; BCLK is never used as a clock.

---
 rtl/i2s_rx_sampler_if.sv | 36 +++
 rtl/i2s_rx_sampler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sampler_if.sv
// i2s_rx_sampler_if
// Bundles the I2S pins coming from the ADC together with the captured-sample
// outputs of the sampler.
//   i2s_bclk, i2s_lrck, i2s_sdata : I2S pins (asynchronous to clk)
//   audio_data[15:0]              : last captured sample of the selected channel
//   data_valid                    : one-clk strobe when audio_data was updated
//   locked                        : a full selected-channel sample was delivered
//                                   and no slot error has happened since
//   err_cnt[7:0]                  : saturating count of short slots
//   dbg_state[1:0]                : capture FSM state (0 idle, 1 shift, 2 hold)
// Modports:
//   master : the sampler (reads the pins, drives the sample outputs)
//   slave  : the ADC / consumer side
// Handshake: data_valid is a strobe with no ready. The consumer must accept
// audio_data in the single cycle data_valid is high; there is no back-pressure.
// audio_data is held unchanged between strobes.
interface i2s_rx_sampler_if;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic [15:0] audio_data;
  logic        data_valid;
  logic        locked;
  logic [7:0]  err_cnt;
  logic [1:0]  dbg_state;

  modport master (
    input  i2s_bclk, i2s_lrck, i2s_sdata,
    output audio_data, data_valid, locked, err_cnt, dbg_state
  );

  modport slave (
    output i2s_bclk, i2s_lrck, i2s_sdata,
    input  audio_data, data_valid, locked, err_cnt, dbg_state
  );
endinterface

// File: rtl/i2s_rx_sampler.sv
// i2s_rx_sampler
// Oversamples an I2S stream (BCLK/LRCK/SDATA) with the system clock and
// deserialises 16-bit samples of one channel. BCLK is only ever sampled, never
// used as a clock, so clk must run at least 8x the BCLK frequency.
// Parameters:
//   CHANNEL : 0 = deliver left (LRCK low), 1 = deliver right (LRCK high)
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : i2s_rx_sampler_if.master (pins in, sample/status out)
module i2s_rx_sampler #(
  parameter bit CHANNEL = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  i2s_rx_sampler_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Pin synchronisers; bclk gets a third stage for edge detection.
  logic bclk_s1, bclk_s2, bclk_s3;
  logic lrck_s1, lrck_s2;
  logic sdata_s1, sdata_s2;

  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        lrck_prev;
  logic        cur_ch;
  logic        word_done;
  logic [15:0] audio_data_q;
  logic        data_valid_q;
  logic        locked_q;
  logic [7:0]  err_cnt_q;

  logic bit_tick;
  logic ws_change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1  <= 1'b0;
      bclk_s2  <= 1'b0;
      bclk_s3  <= 1'b0;
      lrck_s1  <= 1'b0;
      lrck_s2  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      bclk_s1  <= bus.i2s_bclk;
      bclk_s2  <= bclk_s1;
      bclk_s3  <= bclk_s2;
      lrck_s1  <= bus.i2s_lrck;
      lrck_s2  <= lrck_s1;
      sdata_s1 <= bus.i2s_sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  // BCLK rising edge as seen after synchronisation.
  assign bit_tick  = bclk_s2 & ~bclk_s3;
  // The tick on which LRCK changed still carries the previous word's LSB
  // (I2S one-bit delay), so it only restarts a slot and is never shifted in.
  assign ws_change = bit_tick & (lrck_s2 != lrck_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= 16'h0000;
      bit_cnt      <= 5'd0;
      lrck_prev    <= 1'b0;
      cur_ch       <= 1'b0;
      word_done    <= 1'b0;
      audio_data_q <= 16'h0000;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_cnt_q    <= 8'h00;
    end else begin
      data_valid_q <= 1'b0;

      // Output stage runs one clk after the 16th bit landed in shreg.
      if (word_done) begin
        audio_data_q <= shreg;
        data_valid_q <= 1'b1;
        locked_q     <= 1'b1;
        word_done    <= 1'b0;
      end

      if (bit_tick) begin
        lrck_prev <= lrck_s2;
        case (state)
          IDLE: begin
            if (ws_change) begin
              state   <= SHIFT;
              bit_cnt <= 5'd0;
              cur_ch  <= lrck_s2;
            end
          end
          SHIFT: begin
            if (ws_change) begin
              // Slot ended before 16 bits: drop it and start the new one.
              locked_q <= 1'b0;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
              bit_cnt <= 5'd0;
              cur_ch  <= lrck_s2;
            end else begin
              shreg   <= {shreg[14:0], sdata_s2};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                state <= HOLD;
                if (cur_ch == CHANNEL) begin
                  word_done <= 1'b1;
                end
              end
            end
          end
          HOLD: begin
            // Bits beyond the 16th belong to a wider slot and are ignored.
            if (ws_change) begin
              state   <= SHIFT;
              bit_cnt <= 5'd0;
              cur_ch  <= lrck_s2;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.audio_data = audio_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.locked     = locked_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.dbg_state  = state;

endmodule
